// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite slave-side bus bundle for ahb_slave_mem.
// WPROT exists only when AHB_SLV_WPROT_EN is defined.
interface ahb_slave_mem_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
`ifdef AHB_SLV_WPROT_EN
    logic                  WPROT;
`endif
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADYOUT;
    logic                  HRESP;

`ifdef AHB_SLV_WPROT_EN
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, WPROT,
        input  HRDATA, HREADYOUT, HRESP
    );
    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, WPROT,
        output HRDATA, HREADYOUT, HRESP
    );
`else
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );
    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
`endif
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave word memory with configurable wait states.
// Optional write protection via AHB_SLV_WPROT_EN (adds WPROT).
module ahb_slave_mem #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic          HCLK,
    input  logic          HRESET,
    ahb_slave_mem_if.slave bus
);
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-2:0] DEPTH = (ADDR_WIDTH-1)'(MEM_DEPTH);
    localparam logic [3:0] WS_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam bit ZW = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t state, state_nx;

    logic [3:0]            cnt;
    logic                  cnt_ld;
    logic [IW+1:0]         addr_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic                  wpend;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  open, accept, err;
    logic                  bad_idx, bad_size, bad_align, bad_prot;
    logic                  wr_done, rd_load;
    logic [IW-1:0]         wr_idx, rd_idx;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wmerge, rd_word;
    logic                  ready, resp;

    function automatic logic [3:0] lanes(logic [2:0] sz, logic [1:0] a);
        logic [3:0] m;
        m = 4'b1111;
        unique case (1'b1)
            (sz == 3'b000): m = 4'b0001 << a;
            (sz == 3'b001): m = a[1] ? 4'b1100 : 4'b0011;
            default:        m = 4'b1111;
        endcase
        return m;
    endfunction

    assign open   = (state == S_IDLE) || (state == S_ERR2);
    assign accept = open & bus.HSEL & bus.HREADY & bus.HTRANS[1];

    assign bad_idx   = {1'b0, bus.HADDR[ADDR_WIDTH-1:2]} >= DEPTH;
    assign bad_size  = bus.HSIZE > 3'b010;
    assign bad_align = ((bus.HSIZE == 3'b001) & bus.HADDR[0])
                     | ((bus.HSIZE == 3'b010) & (|bus.HADDR[1:0]));
`ifdef AHB_SLV_WPROT_EN
    assign bad_prot  = bus.HWRITE & bus.WPROT;
`else
    assign bad_prot  = 1'b0;
`endif
    assign err = bad_idx | bad_size | bad_align | bad_prot;

    // Write commits in the cycle its data phase completes
    assign wr_done = (state == S_IDLE) && wpend;
    assign wr_idx  = addr_q[IW+1:2];
    assign be      = lanes(size_q, addr_q[1:0]);

    always_comb begin
        wmerge = mem[wr_idx];
        for (int b = 0; b < 4; b++) begin
            if (be[b]) wmerge[8*b +: 8] = bus.HWDATA[8*b +: 8];
        end
    end

    always_comb begin
        rd_load = 1'b0;
        rd_idx  = addr_q[IW+1:2];
        if (ZW) begin
            rd_load = accept & ~err & ~bus.HWRITE;
            rd_idx  = bus.HADDR[IW+1:2];
        end else begin
            rd_load = (state == S_WAIT) && (cnt == 4'd0) && !write_q;
        end
    end

    // Forward a completing write into a back-to-back read of the same word
    assign rd_word = (wr_done && rd_idx == wr_idx) ? wmerge : mem[rd_idx];

    always_comb begin
        state_nx = state;
        ready    = 1'b1;
        resp     = 1'b0;
        cnt_ld   = 1'b0;
        unique case (state)
            S_IDLE, S_ERR2: begin
                resp     = (state == S_ERR2);
                state_nx = S_IDLE;
                if (accept) begin
                    if (err) begin
                        state_nx = S_ERR1;
                    end else if (!ZW) begin
                        state_nx = S_WAIT;
                        cnt_ld   = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                ready = 1'b0;
                if (cnt == 4'd0) state_nx = S_IDLE;
            end
            S_ERR1: begin
                ready    = 1'b0;
                resp     = 1'b1;
                state_nx = S_ERR2;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'b000;
            wpend   <= 1'b0;
            rdata   <= '0;
        end else begin
            state <= state_nx;
            if (cnt_ld) begin
                cnt <= WS_LOAD;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (accept) begin
                addr_q  <= bus.HADDR[IW+1:0];
                write_q <= bus.HWRITE;
                size_q  <= bus.HSIZE;
            end
            if (accept & ~err & bus.HWRITE) begin
                wpend <= 1'b1;
            end else if (wr_done) begin
                wpend <= 1'b0;
            end
            rdata <= rd_load ? rd_word : '0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (wr_done) mem[wr_idx] <= wmerge;
    end

    assign bus.HREADYOUT = ready;
    assign bus.HRESP     = resp;
    assign bus.HRDATA    = rdata;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench: WAIT_STATES=1 instance driven from a vector table,
// WAIT_STATES=0 instance and reset/protection corners by hand.
module tb_ahb_slave_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall1 = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] BZ = 2'b01;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    always #5 clk = ~clk;

    ahb_slave_mem_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) b1();
    ahb_slave_mem_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) b0();

    assign b1.HREADY = b1.HREADYOUT & ~stall1;
    assign b0.HREADY = b0.HREADYOUT;

    ahb_slave_mem #(
        .ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(1)
    ) u1 (
        .HCLK(clk), .HRESET(rst), .bus(b1.slave)
    );

    ahb_slave_mem #(
        .ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)
    ) u0 (
        .HCLK(clk), .HRESET(rst), .bus(b0.slave)
    );

    typedef struct {
        logic        st;
        logic        sel;
        logic [11:0] a;
        logic [1:0]  t;
        logic        w;
        logic [2:0]  sz;
        logic [31:0] wd;
        logic        xr;
        logic        xe;
        logic [31:0] xd;
    } vec_t;

    vec_t v[$];

    function automatic vec_t mk(logic st, logic sel, logic [11:0] a,
                                logic [1:0] t, logic w, logic [2:0] sz,
                                logic [31:0] wd, logic xr, logic xe,
                                logic [31:0] xd);
        vec_t r;
        r.st = st; r.sel = sel; r.a = a; r.t = t; r.w = w; r.sz = sz;
        r.wd = wd; r.xr = xr; r.xe = xe; r.xd = xd;
        return r;
    endfunction

    task automatic chk(input string nm, input logic r, input logic e,
                       input logic [31:0] d, input logic xr,
                       input logic xe, input logic [31:0] xd);
        n_cmp++;
        if (r !== xr || e !== xe || d !== xd) begin
            n_bad++;
            $display("FAIL %s: got rdy=%b resp=%b rdata=%h want rdy=%b resp=%b rdata=%h",
                     nm, r, e, d, xr, xe, xd);
        end
    endtask

    task automatic drv1(logic sel, logic [11:0] a, logic [1:0] t, logic w,
                        logic [2:0] sz, logic [31:0] wd, logic wp);
        b1.HSEL = sel; b1.HADDR = a; b1.HTRANS = t; b1.HWRITE = w;
        b1.HSIZE = sz; b1.HWDATA = wd;
`ifdef AHB_SLV_WPROT_EN
        b1.WPROT = wp;
`else
        if (wp) $display("note: WPROT ignored in this build");
`endif
    endtask

    task automatic drv0(logic sel, logic [11:0] a, logic [1:0] t, logic w,
                        logic [2:0] sz, logic [31:0] wd);
        b0.HSEL = sel; b0.HADDR = a; b0.HTRANS = t; b0.HWRITE = w;
        b0.HSIZE = sz; b0.HWDATA = wd;
`ifdef AHB_SLV_WPROT_EN
        b0.WPROT = 1'b0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic c1(string nm, logic xr, logic xe, logic [31:0] xd);
        @(negedge clk);
        chk(nm, b1.HREADYOUT, b1.HRESP, b1.HRDATA, xr, xe, xd);
    endtask

    task automatic c0(string nm, logic xr, logic xe, logic [31:0] xd);
        @(negedge clk);
        chk(nm, b0.HREADYOUT, b0.HRESP, b0.HRDATA, xr, xe, xd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // v0..v7: word write then read, one wait cycle each
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,1,0,32'h0));
        v.push_back(mk(0,1,12'h010,NS,1,SW,32'h0,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'hDEADBEEF,0,0,32'h0));
        v.push_back(mk(0,1,12'h010,NS,0,SW,32'hDEADBEEF,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,0,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,1,0,32'hDEADBEEF));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,1,0,32'h0));
        // v8..v14: word 11223344, byte AA @011, read merged
        v.push_back(mk(0,1,12'h010,NS,1,SW,32'h0,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h11223344,0,0,32'h0));
        v.push_back(mk(0,1,12'h011,NS,1,SB,32'h11223344,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0000AA00,0,0,32'h0));
        v.push_back(mk(0,1,12'h010,NS,0,SW,32'h0000AA00,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,0,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,1,0,32'h1122AA44));
        // v15..v22: out-of-range and misaligned half reads
        v.push_back(mk(0,1,12'h400,NS,0,SW,32'h0,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,0,1,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,1,1,32'h0));
        v.push_back(mk(0,1,12'h003,NS,0,SH,32'h0,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,0,1,32'h0));
        v.push_back(mk(0,1,12'h010,NS,0,SW,32'h0,1,1,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,0,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,1,0,32'h1122AA44));
        // v23..v28: misaligned word write must not touch memory
        v.push_back(mk(0,1,12'h012,NS,1,SW,32'h0,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'hFFFFFFFF,0,1,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'hFFFFFFFF,1,1,32'h0));
        v.push_back(mk(0,1,12'h010,NS,0,SW,32'h0,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,0,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,1,0,32'h1122AA44));
        // v29..v31: oversize HSIZE
        v.push_back(mk(0,1,12'h000,NS,0,3'b011,32'h0,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,0,1,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,1,1,32'h0));
        // v32..v36: upper half write
        v.push_back(mk(0,1,12'h012,NS,1,SH,32'h0,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'hBEEF0000,0,0,32'h0));
        v.push_back(mk(0,1,12'h010,NS,0,SW,32'hBEEF0000,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,0,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,1,0,32'hBEEFAA44));
        // v37..v39: unselected and BUSY are ignored
        v.push_back(mk(0,0,12'h010,NS,0,SW,32'h0,1,0,32'h0));
        v.push_back(mk(0,1,12'h010,BZ,0,SW,32'h0,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,1,0,32'h0));
        // v40..v44: last valid word
        v.push_back(mk(0,1,12'h3FC,NS,1,SW,32'h0,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'hA5A55A5A,0,0,32'h0));
        v.push_back(mk(0,1,12'h3FC,NS,0,SW,32'hA5A55A5A,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,0,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,1,0,32'hA5A55A5A));
        // v45..v46: HREADY low from elsewhere blocks acceptance
        v.push_back(mk(1,1,12'h010,NS,0,SW,32'h0,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,1,0,32'h0));
        // v47..v50: seed 0x040 for later corners
        v.push_back(mk(0,1,12'h040,NS,1,SW,32'h0,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0BADF00D,0,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0BADF00D,1,0,32'h0));
        v.push_back(mk(0,0,12'h000,ID,0,SW,32'h0,1,0,32'h0));

        drv1(0, 12'h0, ID, 0, SW, 32'h0, 0);
        drv0(0, 12'h0, ID, 0, SW, 32'h0);
        c1("rst_u1", 1'b1, 1'b0, 32'h0);
        c0("rst_u0", 1'b1, 1'b0, 32'h0);
        step();
        rst = 1'b0;

        foreach (v[i]) begin
            step();
            stall1 = v[i].st;
            drv1(v[i].sel, v[i].a, v[i].t, v[i].w, v[i].sz, v[i].wd, 0);
            c1($sformatf("vec%0d", i), v[i].xr, v[i].xe, v[i].xd);
        end
        stall1 = 1'b0;

        // Reset during a write wait cycle discards the write
        step(); drv1(1, 12'h040, NS, 1, SW, 32'h0, 0);
        c1("mrst_addr", 1'b1, 1'b0, 32'h0);
        step(); drv1(0, 12'h000, ID, 0, SW, 32'h12345678, 0);
        c1("mrst_wait", 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        chk("mrst_async", b1.HREADYOUT, b1.HRESP, b1.HRDATA,
            1'b1, 1'b0, 32'h0);
        step(); rst = 1'b0;
        drv1(1, 12'h040, NS, 0, SW, 32'h12345678, 0);
        c1("mrst_rd_addr", 1'b1, 1'b0, 32'h0);
        step(); drv1(0, 12'h000, ID, 0, SW, 32'h0, 0);
        c1("mrst_rd_wait", 1'b0, 1'b0, 32'h0);
        step();
        c1("mrst_rd_data", 1'b1, 1'b0, 32'h0BADF00D);

`ifdef AHB_SLV_WPROT_EN
        step(); drv1(1, 12'h040, NS, 1, SW, 32'h0, 1);
        c1("wp_addr", 1'b1, 1'b0, 32'h0);
        step(); drv1(0, 12'h000, ID, 0, SW, 32'h12345678, 0);
        c1("wp_err1", 1'b0, 1'b1, 32'h0);
        step(); drv1(1, 12'h040, NS, 0, SW, 32'h12345678, 0);
        c1("wp_err2", 1'b1, 1'b1, 32'h0);
        step(); drv1(0, 12'h000, ID, 0, SW, 32'h0, 0);
        c1("wp_rd_wait", 1'b0, 1'b0, 32'h0);
        step();
        c1("wp_rd_data", 1'b1, 1'b0, 32'h0BADF00D);
`endif

        // Zero-wait instance: back-to-back write/read forwarding
        step(); drv0(1, 12'h020, NS, 1, SW, 32'h0);
        c0("zw_wr_addr", 1'b1, 1'b0, 32'h0);
        step(); drv0(1, 12'h020, NS, 0, SW, 32'h0000CAFE);
        c0("zw_no_wait", 1'b1, 1'b0, 32'h0);
        step(); drv0(0, 12'h000, ID, 0, SW, 32'h0);
        c0("zw_raw_fwd", 1'b1, 1'b0, 32'h0000CAFE);
        step(); drv0(1, 12'h024, NS, 1, SW, 32'h0);
        c0("zw_rd_clear", 1'b1, 1'b0, 32'h0);
        step(); drv0(1, 12'h026, NS, 1, SB, 32'h11223344);
        c0("zw_wr2", 1'b1, 1'b0, 32'h0);
        step(); drv0(1, 12'h024, NS, 0, SW, 32'h00770000);
        c0("zw_wr3", 1'b1, 1'b0, 32'h0);
        step(); drv0(0, 12'h000, ID, 0, SW, 32'h0);
        c0("zw_merge_fwd", 1'b1, 1'b0, 32'h11773344);
        step(); drv0(1, 12'h400, NS, 0, SW, 32'h0);
        c0("zw_idle", 1'b1, 1'b0, 32'h0);
        step(); drv0(0, 12'h000, ID, 0, SW, 32'h0);
        c0("zw_err1", 1'b0, 1'b1, 32'h0);
        step();
        c0("zw_err2", 1'b1, 1'b1, 32'h0);
        step();
        c0("zw_after_err", 1'b1, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
